bus_cycle_gen: RTL and testbench

- Upstream master for the memory/IO bus model: turns single-byte transfer requests from the CPU core into 8086-style T1–T4 bus cycles.
- Drives ALE, IOM, RD, WR and Address; drives write data; captures read data; returns a response to the core.
- Supports READY-driven wait states and a watchdog timeout that aborts the cycle with an error.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_wait_timer.sv | 28 ++
 rtl/bus_cycle_gen.sv | 133 +++++++++++++
 tb/tb_bus_cycle_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the 8086-style bus cycle generator.
package bus_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 8;

    localparam logic IOM_IO  = 1'b1;
    localparam logic IOM_MEM = 1'b0;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } bus_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic                  io;
        logic                  write;
        logic [DATA_W_DEF-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter: counts TW cycles and flags when MAX_WAIT is reached.
module bus_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [7:0] count;

    // NOTE: asynchronous reset sits in the sensitivity list so it acts without a clock edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    // The FSM stops enabling at the terminal value, so the counter never wraps.
    assign done = (count == 8'(MAX_WAIT));

endmodule

// File: rtl/bus_cycle_gen.sv
// Turns single-byte core requests into T1-T4 bus cycles with READY wait
// states and a watchdog abort.
module bus_cycle_gen
    import bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_io,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ALE,
    output logic              IOM,
    output logic              RD,
    output logic              WR,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              READY,
    output logic              busy
);

    bus_state_t state;
    bus_req_t   hold;
    logic       wait_clr;
    logic       wait_en;
    logic       wait_done;
    logic       cycle_end;

    assign wait_clr  = (state == IDLE) || (state == T4);
    assign wait_en   = !READY && ((state == T3) || ((state == TW) && !wait_done));
    assign cycle_end = READY || ((state == TW) && wait_done);

    // Address and IOM come straight from the holding flops, stable T1..T4.
    assign Address = ADDR_W'(hold.addr);
    assign IOM     = hold.io;

    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (wait_clr),
        .en    (wait_en),
        .done  (wait_done)
    );

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            hold      <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            ALE       <= 1'b0;
            RD        <= 1'b1;
            WR        <= 1'b1;
            Data_out  <= '0;
            Data_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_ready && req_valid) begin
                        hold.addr  <= ADDR_W_DEF'(req_addr);
                        hold.io    <= req_io ? IOM_IO : IOM_MEM;
                        hold.write <= req_write;
                        hold.wdata <= DATA_W_DEF'(req_wdata);
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        ALE        <= 1'b1;
                        state      <= T1;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                T1: begin
                    ALE <= 1'b0;
                    if (hold.write) begin
                        WR       <= 1'b0;
                        Data_oe  <= 1'b1;
                        Data_out <= DATA_W'(hold.wdata);
                    end else begin
                        RD <= 1'b0;
                    end
                    state <= T2;
                end
                T2: begin
                    state <= T3;
                end
                T3, TW: begin
                    if (cycle_end) begin
                        if (READY && !hold.write) begin
                            rsp_rdata <= Data_in;
                        end
                        RD        <= 1'b1;
                        WR        <= 1'b1;
                        Data_oe   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !READY;
                        state     <= T4;
                    end else begin
                        state <= TW;
                    end
                end
                T4: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Directed self-checking bench for bus_cycle_gen with a small byte memory slave.
module tb_bus_cycle_gen;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_addr;
    logic        req_io;
    logic        req_write;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ALE;
    logic        IOM;
    logic        RD;
    logic        WR;
    logic [19:0] Address;
    logic [7:0]  Data_out;
    logic        Data_oe;
    logic [7:0]  Data_in;
    logic        READY;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:255];
    logic       use_mem;
    logic [7:0] tb_din;

    assign Data_in = use_mem ? mem[Address[7:0]] : tb_din;

    always @(posedge CLK) begin
        if (WR === 1'b0) mem[Address[7:0]] <= Data_out;
    end

    always #5 CLK = ~CLK;

    bus_cycle_gen #(
        .ADDR_W   (20),
        .DATA_W   (8),
        .MAX_WAIT (15)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_io    (req_io),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ALE       (ALE),
        .IOM       (IOM),
        .RD        (RD),
        .WR        (WR),
        .Address   (Address),
        .Data_out  (Data_out),
        .Data_oe   (Data_oe),
        .Data_in   (Data_in),
        .READY     (READY),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic request(input logic [19:0] a, input logic io, input logic wr, input logic [7:0] wd);
        req_valid = 1'b1;
        req_addr  = a;
        req_io    = io;
        req_write = wr;
        req_wdata = wd;
    endtask

    initial begin
        int early;
        int ale1;
        int ale2;
        int rsp_cyc;
        logic [7:0] rd_seen;

        RESET = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_io = 1'b0; req_write = 1'b0; req_wdata = '0;
        READY = 1'b1; use_mem = 1'b0; tb_din = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset values
        tick(); tick();
        check("rst_ale", ALE, 0);
        check("rst_iom", IOM, 0);
        check("rst_rd_wr", {RD, WR}, 2'b11);
        check("rst_addr", Address, 0);
        check("rst_dout_oe", {Data_out, Data_oe}, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("rst_busy_ready", {busy, req_ready}, 0);
        RESET = 1'b0;
        #1;
        check("rel_ready_low", req_ready, 0);
        tick();
        check("rel_ready_high", req_ready, 1);

        // Memory write 0_1234 <- A5, READY=1
        request(20'h01234, 1'b0, 1'b1, 8'hA5);
        tick();
        check("wr_t1_ale", ALE, 1);
        check("wr_t1_addr", Address, 20'h01234);
        check("wr_t1_iom", IOM, 0);
        check("wr_t1_strobes", {RD, WR, req_ready, busy}, 4'b1101);
        req_valid = 1'b0; req_addr = 20'hFFFFF; req_wdata = 8'h00;
        tick();
        check("wr_t2", {ALE, RD, WR, Data_oe}, 4'b0101);
        check("wr_t2_dout", Data_out, 8'hA5);
        tick();
        check("wr_t3", {WR, Data_oe, Address}, {2'b01, 20'h01234});
        tick();
        check("wr_t4_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("wr_t4_bus", {WR, RD, Data_oe}, 3'b110);
        tick();
        check("wr_idle", {rsp_valid, busy, req_ready}, 3'b001);

        // IO read 0_0060, Data_in=3C
        tb_din = 8'h3C;
        request(20'h00060, 1'b1, 1'b0, 8'h00);
        tick();
        req_valid = 1'b0;
        check("ior_t1", {ALE, IOM, Address}, {2'b11, 20'h00060});
        tick();
        check("ior_t2", {RD, WR, Data_oe, IOM}, 4'b0101);
        tick();
        check("ior_t3", {RD, IOM}, 2'b01);
        tick();
        check("ior_t4", {rsp_valid, rsp_err, RD, IOM}, 4'b1011);
        check("ior_rdata", rsp_rdata, 8'h3C);
        tick();

        // Memory read with 3 wait states
        tb_din = 8'h55;
        READY = 1'b0;
        request(20'h0ABCD, 1'b0, 1'b0, 8'h00);
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("wt_t3_rd", RD, 0);
        tick();
        check("wt_tw1", {RD, rsp_valid, busy}, 3'b001);
        tick();
        check("wt_tw2_hold", rsp_rdata, 8'h3C);
        tick();
        check("wt_tw3", {RD, rsp_valid}, 2'b00);
        READY = 1'b1;
        tb_din = 8'h7E;
        tick();
        check("wt_c7_rsp", {rsp_valid, rsp_err, RD}, 3'b101);
        check("wt_rdata", rsp_rdata, 8'h7E);
        tick();

        // Timeout abort: READY never rises
        READY = 1'b0;
        tb_din = 8'hEE;
        request(20'h00100, 1'b0, 1'b0, 8'h00);
        early = 0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            req_valid = 1'b0;
            if (rsp_valid) early++;
        end
        check("to_no_early_rsp", early, 0);
        check("to_c18_rd", RD, 0);
        tick();
        check("to_c19_rsp", {rsp_valid, rsp_err, RD}, 3'b111);
        check("to_rdata_kept", rsp_rdata, 8'h7E);
        tick();
        check("to_idle", {rsp_valid, rsp_err, busy, req_ready}, 4'b0001);

        // Back-to-back write then read of 0x00010 through the memory model
        READY = 1'b1;
        use_mem = 1'b1;
        request(20'h00010, 1'b0, 1'b1, 8'h11);
        ale1 = 0; ale2 = 0; rsp_cyc = 0; rd_seen = 8'h00;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) request(20'h00010, 1'b0, 1'b0, 8'h99);
            if (c == 2) check("b2b_hold_write", {WR, RD, Data_out}, {2'b01, 8'h11});
            if (c == 6) req_valid = 1'b0;
            if (ALE && ale1 == 0) ale1 = c;
            else if (ALE) ale2 = c;
            if (rsp_valid && c > 4) begin
                rsp_cyc = c;
                rd_seen = rsp_rdata;
            end
        end
        check("b2b_ale_gap", ale2 - ale1, 5);
        check("b2b_rsp_cycle", rsp_cyc, 9);
        check("b2b_rdata", rd_seen, 8'h11);
        use_mem = 1'b0;

        // Reset asserted during T2 of a read
        tb_din = 8'h42;
        request(20'h00200, 1'b0, 1'b0, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_t2_rd", RD, 0);
        RESET = 1'b1;
        #1;
        check("mid_rst_rd", {RD, WR, busy, req_ready}, 4'b1100);
        check("mid_rst_addr", Address, 0);
        tick();
        check("mid_rst_rsp", {rsp_valid, rsp_rdata}, 0);
        RESET = 1'b0;
        tick();
        check("mid_rel_ready", {req_ready, busy, rsp_valid}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
